// File: rtl/rob_param.sv
// Parameterised reorder buffer: in-order allocate and retire, out-of-order completion
// over a CDB, operand lookup with CDB bypass, and flush on a retiring taken branch.
module rob_param #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_disp_valid,
    input  logic [2:0]       i_disp_type,
    input  logic [4:0]       i_disp_rd,
    input  logic [XLEN-1:0]  i_disp_pc,
    output logic             o_disp_ready,
    output logic [TAG_W-1:0] o_disp_tag,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [XLEN-1:0]  i_cdb_data,
    input  logic             i_cdb_taken,
    input  logic [TAG_W-1:0] i_rs1_tag,
    input  logic [TAG_W-1:0] i_rs2_tag,
    output logic             o_rs1_ready,
    output logic             o_rs2_ready,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic             o_ret_valid,
    output logic [TAG_W-1:0] o_ret_tag,
    output logic [4:0]       o_ret_rd,
    output logic [XLEN-1:0]  o_ret_data,
    output logic [XLEN-1:0]  o_ret_pc,
    output logic [2:0]       o_ret_type,
    input  logic             i_store_ack,
    output logic             o_flush,
    output logic [TAG_W:0]   o_count
);
    localparam logic [2:0]     TYPE_STORE  = 3'd4;
    localparam logic [2:0]     TYPE_BRANCH = 3'd5;
    localparam logic [2:0]     TYPE_JUMP   = 3'd6;
    localparam logic [TAG_W:0] FULL_COUNT  = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] taken_q, taken_d;
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [2:0]       type_mem [DEPTH];
    logic [4:0]       rd_mem   [DEPTH];
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];

    logic ret_valid, ret_fire, flush, disp_ready, alloc, cdb_wr;

    assign ret_valid  = valid_q[head_q] & done_q[head_q];
    assign ret_fire   = ret_valid & ((type_mem[head_q] != TYPE_STORE) | i_store_ack);
    assign flush      = ret_fire & (type_mem[head_q] == TYPE_BRANCH) & taken_q[head_q];
    assign disp_ready = (count_q < FULL_COUNT) & ~flush;
    assign alloc      = i_disp_valid & disp_ready & (i_disp_type != TYPE_JUMP);
    // A flush discards the same-cycle completion as well as the dispatch.
    assign cdb_wr     = i_cdb_valid & valid_q[i_cdb_tag] & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic alloc_hit, cdb_hit, ret_hit;
            assign alloc_hit   = alloc & (tail_q == TAG_W'(gi));
            assign cdb_hit     = cdb_wr & (i_cdb_tag == TAG_W'(gi));
            assign ret_hit     = ret_fire & (head_q == TAG_W'(gi));
            assign valid_d[gi] = flush ? 1'b0 : alloc_hit ? 1'b1 : ret_hit ? 1'b0 : valid_q[gi];
            assign done_d[gi]  = flush ? 1'b0 : alloc_hit ? 1'b0 : cdb_hit ? 1'b1 : done_q[gi];
            assign taken_d[gi] = flush ? 1'b0 : alloc_hit ? 1'b0 : cdb_hit ? i_cdb_taken : taken_q[gi];
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (ret_fire) head_d = head_q + TAG_W'(1);
            if (alloc)    tail_d = tail_q + TAG_W'(1);
            unique case ({alloc, ret_fire})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            done_q  <= '0;
            taken_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            taken_q <= taken_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is never reset; the valid/done bits qualify every use of it.
    always_ff @(posedge i_clk) begin
        if (!i_rst && alloc) begin
            type_mem[tail_q] <= i_disp_type;
            rd_mem[tail_q]   <= i_disp_rd;
            pc_mem[tail_q]   <= i_disp_pc;
            data_mem[tail_q] <= '0;
        end
        if (!i_rst && cdb_wr) data_mem[i_cdb_tag] <= i_cdb_data;
    end

    logic [TAG_W-1:0] rs_tag   [2];
    logic             rs_ready [2];
    logic [XLEN-1:0]  rs_data  [2];
    assign rs_tag[0] = i_rs1_tag;
    assign rs_tag[1] = i_rs2_tag;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic hit_valid, bypass;
            assign hit_valid    = valid_q[rs_tag[gi]];
            assign bypass       = hit_valid & i_cdb_valid & (i_cdb_tag == rs_tag[gi]);
            assign rs_ready[gi] = bypass | (hit_valid & done_q[rs_tag[gi]]);
            assign rs_data[gi]  = bypass ? i_cdb_data : (hit_valid ? data_mem[rs_tag[gi]] : '0);
        end
    endgenerate

    assign o_rs1_ready  = rs_ready[0];
    assign o_rs2_ready  = rs_ready[1];
    assign o_rs1_data   = rs_data[0];
    assign o_rs2_data   = rs_data[1];

    assign o_disp_ready = disp_ready;
    assign o_disp_tag   = tail_q;
    assign o_ret_valid  = ret_valid;
    assign o_ret_tag    = head_q;
    assign o_ret_rd     = rd_mem[head_q];
    assign o_ret_data   = data_mem[head_q];
    assign o_ret_pc     = pc_mem[head_q];
    assign o_ret_type   = type_mem[head_q];
    assign o_flush      = flush;
    assign o_count      = count_q;
endmodule
